// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single DMEM port between two requesters:
//   port 0 : core LSU
//   port 1 : debug / DMA loader
//
// Each cycle one request is chosen and its payload is driven onto the DMEM
// interface. Stores commit on the accepting edge. The DMEM read data is
// registered, so the winner gets its response (data or error) one cycle later.
// Alignment and range are checked before a write is allowed to reach memory.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN,    request N (N=0,1); payload held stable
//   load_selN, store_selN        until gntN
//   gntN                         combinational accept
//   rvalidN, rdataN, errN        registered response for the previous accept
//   mem_addr, mem_dataW,         DMEM request (winner's payload; port 0's
//   mem_load_sel, mem_store_sel, payload when nothing is granted)
//   mem_wr_en
//   mem_dataR                    DMEM combinational read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MEM_NBYTE = 1024,
  parameter int RR_MODE   = 0,
  parameter int MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [2:0]  load_sel0,
  input  logic [1:0]  store_sel0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  output logic        err0,

  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [2:0]  load_sel1,
  input  logic [1:0]  store_sel1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        err1,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataW,
  output logic [2:0]  mem_load_sel,
  output logic [1:0]  mem_store_sel,
  output logic        mem_wr_en,
  input  logic [31:0] mem_dataR
);

  // Load/store type encodings (funct3-style; unlisted codes are reserved).
  localparam logic [2:0] LOAD_SEL_LB  = 3'd0;
  localparam logic [2:0] LOAD_SEL_LH  = 3'd1;
  localparam logic [2:0] LOAD_SEL_LW  = 3'd2;
  localparam logic [2:0] LOAD_SEL_LBU = 3'd4;
  localparam logic [2:0] LOAD_SEL_LHU = 3'd5;

  localparam logic [1:0] STORE_SEL_SB = 2'd0;
  localparam logic [1:0] STORE_SEL_SH = 2'd1;
  localparam logic [1:0] STORE_SEL_SW = 2'd2;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

  localparam int              WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [63:0]     MEM_LIMIT  = 64'(MEM_NBYTE);

  // State
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              rr_last_q,  rr_last_d;
  logic              rvalid0_q,  rvalid0_d;
  logic              rvalid1_q,  rvalid1_d;
  logic [31:0]       rdata0_q,   rdata0_d;
  logic [31:0]       rdata1_q,   rdata1_d;
  logic              err0_q,     err0_d;
  logic              err1_q,     err1_d;

  // Selected request
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [2:0]  sel_lsel;
  logic [1:0]  sel_ssel;
  logic        accept;
  logic [2:0]  acc_size;
  logic        bad_code;
  logic        misaligned;
  logic        out_of_range;
  logic        acc_err;
  logic [31:0] resp_data;

  // ---------------------------------------------------------------------------
  // Arbitration. Nothing is granted while reset is high, which also keeps
  // mem_wr_en low in the reset cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        if (RR_MODE != 0) begin
          // Alternate: the port that did not win last time goes now.
          gnt1 = (rr_last_q == 1'b0);
        end else begin
          // Port 0 has priority until port 1 has been refused MAX_WAIT times.
          gnt1 = (wait_cnt_q == WAIT_LIMIT);
        end
        gnt0 = !gnt1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign accept = gnt0 | gnt1;

  // DMEM mux: port 1 only drives the bus when it holds the grant.
  always_comb begin
    sel_we   = gnt1 ? we1        : we0;
    sel_addr = gnt1 ? addr1      : addr0;
    sel_lsel = gnt1 ? load_sel1  : load_sel0;
    sel_ssel = gnt1 ? store_sel1 : store_sel0;
  end

  assign mem_addr      = sel_addr;
  assign mem_dataW     = gnt1 ? wdata1 : wdata0;
  assign mem_load_sel  = sel_lsel;
  assign mem_store_sel = sel_ssel;

  // ---------------------------------------------------------------------------
  // Access check on the selected request.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_size = 3'd1;
    bad_code = 1'b0;
    if (sel_we) begin
      case (sel_ssel)
        STORE_SEL_SB: acc_size = 3'd1;
        STORE_SEL_SH: acc_size = 3'd2;
        STORE_SEL_SW: acc_size = 3'd4;
        default:      bad_code = 1'b1;
      endcase
    end else begin
      case (sel_lsel)
        LOAD_SEL_LB, LOAD_SEL_LBU: acc_size = 3'd1;
        LOAD_SEL_LH, LOAD_SEL_LHU: acc_size = 3'd2;
        LOAD_SEL_LW:               acc_size = 3'd4;
        default:                   bad_code = 1'b1;
      endcase
    end
  end

  always_comb begin
    misaligned = ((acc_size == 3'd2) && sel_addr[0]) ||
                 ((acc_size == 3'd4) && (sel_addr[1:0] != 2'b00));
    // Widened so an address near 2^32 cannot wrap back into range.
    out_of_range = ({32'd0, sel_addr} + {61'd0, acc_size}) > MEM_LIMIT;
    acc_err      = bad_code || misaligned || out_of_range;
  end

  assign mem_wr_en = (accept && sel_we && !acc_err) ? MEM_WRITE : MEM_READ;

  // Only an error-free load returns memory data.
  assign resp_data = (!sel_we && !acc_err) ? mem_dataR : 32'd0;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    rr_last_d  = rr_last_q;
    rvalid0_d  = gnt0;
    rvalid1_d  = gnt1;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    err0_d     = err0_q;
    err1_d     = err1_q;

    if (req1 && !gnt1) begin
      if (wait_cnt_q != WAIT_LIMIT) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      wait_cnt_d = '0;
    end

    if (accept) begin
      rr_last_d = gnt1;
    end

    if (gnt0) begin
      rdata0_d = resp_data;
      err0_d   = acc_err;
    end
    if (gnt1) begin
      rdata1_d = resp_data;
      err1_d   = acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rr_last_q  <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= 32'd0;
      rdata1_q   <= 32'd0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rr_last_q  <= rr_last_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

endmodule
